// File: rtl/alu_seq_host.sv
// alu_seq_host: sequences one request into a nibble-serial ALU
// and returns its result, flags, or a timeout indication.
module alu_seq_host #(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op1,
  input  logic [3:0] req_op2,
  input  logic [3:0] req_opcode,
  output logic       alu_reset,
  output logic [3:0] alu_data,
  input  logic [3:0] alu_result,
  input  logic [3:0] alu_flags,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_result,
  output logic [2:0] rsp_flags,
  output logic       rsp_timeout
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CLR     = 3'd1;
  localparam logic [2:0] SEND_A  = 3'd2;
  localparam logic [2:0] SEND_B  = 3'd3;
  localparam logic [2:0] SEND_OP = 3'd4;
  localparam logic [2:0] WAIT    = 3'd5;
  localparam logic [2:0] RESP    = 3'd6;

  localparam logic [3:0] TMO = 4'(TIMEOUT_CYCLES);

  logic [2:0] state;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       live;
  logic [3:0] op1_q;
  logic [3:0] op2_q;
  logic [3:0] opc_q;
  logic       done;

  assign cnt_nxt = cnt + 4'd1;
  assign done    = alu_flags[0];

  // live holds the ALU in reset and blocks requests until the
  // first clock edge after reset is released
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      live        <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      opc_q       <= '0;
      rsp_result  <= '0;
      rsp_flags   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      live <= 1'b1;
      unique case (state)
        IDLE: begin
          if (req_valid && live) begin
            op1_q <= req_op1;
            op2_q <= req_op2;
            opc_q <= req_opcode;
            state <= CLR;
          end
        end
        CLR:    state <= SEND_A;
        SEND_A: state <= SEND_B;
        SEND_B: state <= SEND_OP;
        SEND_OP: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt_nxt;
          if (done) begin
            rsp_result  <= alu_result;
            rsp_flags   <= alu_flags[3:1];
            rsp_timeout <= 1'b0;
            state       <= RESP;
          end else if (cnt_nxt == TMO) begin
            rsp_result  <= '0;
            rsp_flags   <= '0;
            rsp_timeout <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // nibble bus driver: operands only in the three send states
  always_comb begin
    alu_data = '0;
    unique case (1'b1)
      state == SEND_A:  alu_data = op1_q;
      state == SEND_B:  alu_data = op2_q;
      state == SEND_OP: alu_data = opc_q;
      default:          alu_data = '0;
    endcase
  end

  assign alu_reset = !live || (state == CLR);
  assign req_ready = live && (state == IDLE);
  assign rsp_valid = (state == RESP);

endmodule
